mmt_sync_deglitch: RTL and testbench
====================================

MMT_SYNC_DEGLITCH -- requirements
Module: mmt_sync_deglitch

Interface
REQ-001 SHALL have parameter FilterCycles, default 4, range 1..255: consecutive cycles a new input level must hold before acceptance.
REQ-002 SHALL have parameter CntWidth, default 8, range 2..32: width of each edge statistics counter.
REQ-003 SHALL have parameter ResetValue, default 1'b0: reset level of out_level.
REQ-004 SHALL have port clk, input, 1, sole clock; all logic SHALL be on its rising edge.
REQ-005 SHALL have port rstn, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port in, input, 1, level from the upstream mmt_sync_single out, already in the clk domain.
REQ-007 SHALL have port out_level, output, 1, filtered level.
REQ-008 SHALL have port rise_pulse, output, 1, one-cycle strobe on accepted 0->1.
REQ-009 SHALL have port fall_pulse, output, 1, one-cycle strobe on accepted 1->0.
REQ-010 SHALL have port cnt_clr, input, 1, synchronous clear of both statistics counters.
REQ-011 SHALL have port rise_cnt, output, CntWidth, count of accepted rises.
REQ-012 SHALL have port fall_cnt, output, CntWidth, count of accepted falls.

Function
REQ-013 SHALL implement an FSM with states STABLE_LO, QUAL_HI, STABLE_HI, QUAL_LO and a qualify counter of width clog2(FilterCycles+1).
REQ-014 In STABLE_x, in equal to out_level SHALL hold state; differing in SHALL move to QUAL_(new level) with qualify count 1.
REQ-015 In QUAL_x, in at the candidate level SHALL increment the count; in back at out_level SHALL return to STABLE_(out_level), count 0, with no output change.
REQ-016 On the edge where the count would reach FilterCycles, out_level SHALL take the candidate level, FSM SHALL enter STABLE_(new), count SHALL clear.
REQ-017 Latency: a level held from sampling edge k SHALL appear on out_level after edge k+FilterCycles-1; FilterCycles=1 gives a pure one-cycle register (QUAL states bypassed).
REQ-018 Glitches shorter than FilterCycles cycles SHALL produce no out_level change and no pulse.
REQ-019 rise_pulse/fall_pulse SHALL be registered, high exactly in the first cycle out_level shows the new level, never both high.
REQ-020 Counters SHALL increment by 1 in the cycle the corresponding pulse is high and SHALL saturate at all-ones without wrapping.
REQ-021 cnt_clr SHALL zero both counters on the next edge; simultaneous cnt_clr and pulse SHALL yield 0 (clear wins).
REQ-022 All outputs SHALL be driven from flops; no combinational in-to-out path.

Reset
REQ-023 rstn low SHALL immediately force out_level=ResetValue, FSM=STABLE_(ResetValue), qualify count 0, pulses 0, counters 0, including mid-qualification.
REQ-024 After rstn rises, an in differing from ResetValue SHALL require the full FilterCycles qualification; no pulse SHALL be generated by reset itself.

Configuration
REQ-025 Macro MMT_DEGLITCH_STAT_EN defined: rise_cnt/fall_cnt logic per REQ-020/021 compiled in.
REQ-026 Macro MMT_DEGLITCH_STAT_EN undefined: no counter flops; rise_cnt/fall_cnt tied to 0; cnt_clr ignored; filter and pulses unchanged.

Verification (FilterCycles=4, CntWidth=8, ResetValue=0, 10 ns clk, unless stated)
REQ-027 Reset release, in=1 held from edge 0 -> out_level=1 and rise_pulse=1 after edge 3 for one cycle, rise_cnt=1.
REQ-028 in=1 for 3 cycles then 0 -> out_level stays 0, no pulses, rise_cnt=0; then in=1 for 4 cycles -> accepted.
REQ-029 out_level=1, then in=0 held -> fall_pulse single cycle after 4th sampling edge, fall_cnt=1; glitch 1-0-1 mid-qualify restarts count.
REQ-030 300 accepted rise/fall pairs -> rise_cnt=fall_cnt=255 (saturated); cnt_clr coincident with a rise_pulse -> rise_cnt=0 next cycle.
REQ-031 rstn asserted asynchronously (between edges) during QUAL_HI with count 3 -> out_level=0, pulses 0, counters 0 immediately; in=1 still needs 4 cycles after release.
REQ-032 Build without MMT_DEGLITCH_STAT_EN, rerun REQ-027 -> identical out_level/pulse timing, rise_cnt=fall_cnt=0 throughout.

Source files
------------

// File: rtl/mmt_sync_deglitch.sv
// ============================================================================
// mmt_sync_deglitch : level deglitch filter with edge strobes and edge counters
// Optional statistics counters: define MMT_DEGLITCH_STAT_EN
// Revision: 1.0
// ============================================================================
`default_nettype none

module mmt_sync_deglitch #(
    parameter int   FilterCycles = 4,
    parameter int   CntWidth     = 8,
    parameter logic ResetValue   = 1'b0
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                in,
    output logic                out_level,
    output logic                rise_pulse,
    output logic                fall_pulse,
    input  logic                cnt_clr,
    output logic [CntWidth-1:0] rise_cnt,
    output logic [CntWidth-1:0] fall_cnt
);

    localparam int QW = $clog2(FilterCycles + 1);
    localparam logic [QW-1:0] QUAL_ONE  = QW'(1);
    localparam logic [QW-1:0] QUAL_DONE = QW'(FilterCycles);

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        QUAL_HI   = 2'd1,
        STABLE_HI = 2'd2,
        QUAL_LO   = 2'd3
    } state_t;

    localparam state_t RESET_STATE = ResetValue ? STABLE_HI : STABLE_LO;

    state_t        state_q, state_d;
    logic [QW-1:0] qcnt_q, qcnt_d;
    logic          out_q, out_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;

    always_comb begin
        state_d = state_q;
        qcnt_d  = qcnt_q;
        out_d   = out_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            STABLE_LO: begin
                if (in) begin
                    // A one-cycle filter accepts on the first differing sample.
                    if (FilterCycles == 1) begin
                        out_d   = 1'b1;
                        rise_d  = 1'b1;
                        state_d = STABLE_HI;
                    end else begin
                        state_d = QUAL_HI;
                        qcnt_d  = QUAL_ONE;
                    end
                end
            end
            QUAL_HI: begin
                if (!in) begin
                    state_d = STABLE_LO;
                    qcnt_d  = '0;
                end else if (qcnt_q + QUAL_ONE == QUAL_DONE) begin
                    out_d   = 1'b1;
                    rise_d  = 1'b1;
                    state_d = STABLE_HI;
                    qcnt_d  = '0;
                end else begin
                    qcnt_d  = qcnt_q + QUAL_ONE;
                end
            end
            STABLE_HI: begin
                if (!in) begin
                    if (FilterCycles == 1) begin
                        out_d   = 1'b0;
                        fall_d  = 1'b1;
                        state_d = STABLE_LO;
                    end else begin
                        state_d = QUAL_LO;
                        qcnt_d  = QUAL_ONE;
                    end
                end
            end
            QUAL_LO: begin
                if (in) begin
                    state_d = STABLE_HI;
                    qcnt_d  = '0;
                end else if (qcnt_q + QUAL_ONE == QUAL_DONE) begin
                    out_d   = 1'b0;
                    fall_d  = 1'b1;
                    state_d = STABLE_LO;
                    qcnt_d  = '0;
                end else begin
                    qcnt_d  = qcnt_q + QUAL_ONE;
                end
            end
            default: begin
                state_d = RESET_STATE;
                qcnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= RESET_STATE;
            qcnt_q  <= '0;
            out_q   <= ResetValue;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            qcnt_q  <= qcnt_d;
            out_q   <= out_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign out_level  = out_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;

`ifdef MMT_DEGLITCH_STAT_EN
    logic [CntWidth-1:0] rise_cnt_q, rise_cnt_d;
    logic [CntWidth-1:0] fall_cnt_q, fall_cnt_d;

    // Counters advance on the edge closing a pulse cycle; a clear always wins.
    always_comb begin
        rise_cnt_d = rise_cnt_q;
        fall_cnt_d = fall_cnt_q;
        if (cnt_clr) begin
            rise_cnt_d = '0;
            fall_cnt_d = '0;
        end else begin
            if (rise_q && (rise_cnt_q != '1)) begin
                rise_cnt_d = rise_cnt_q + CntWidth'(1);
            end
            if (fall_q && (fall_cnt_q != '1)) begin
                fall_cnt_d = fall_cnt_q + CntWidth'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rise_cnt_q <= '0;
            fall_cnt_q <= '0;
        end else begin
            rise_cnt_q <= rise_cnt_d;
            fall_cnt_q <= fall_cnt_d;
        end
    end

    assign rise_cnt = rise_cnt_q;
    assign fall_cnt = fall_cnt_q;
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign rise_cnt       = '0;
    assign fall_cnt       = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mmt_sync_deglitch.sv
// ============================================================================
// tb_mmt_sync_deglitch : directed bench for the deglitch filter
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mmt_sync_deglitch;

`ifdef MMT_DEGLITCH_STAT_EN
    localparam bit STAT = 1'b1;
`else
    localparam bit STAT = 1'b0;
`endif

    logic       clk;
    logic       rstn;
    logic       in_s;
    logic       cnt_clr;
    logic       out0, rise0, fall0;
    logic [7:0] rcnt0, fcnt0;
    logic       out1, rise1, fall1;
    logic [1:0] rcnt1, fcnt1;

    int n_checks = 0;
    int n_errors = 0;
    bit chk1_en  = 1'b0;

    mmt_sync_deglitch #(
        .FilterCycles (4),
        .CntWidth     (8),
        .ResetValue   (1'b0)
    ) u_dut (
        .clk        (clk),
        .rstn       (rstn),
        .in         (in_s),
        .out_level  (out0),
        .rise_pulse (rise0),
        .fall_pulse (fall0),
        .cnt_clr    (cnt_clr),
        .rise_cnt   (rcnt0),
        .fall_cnt   (fcnt0)
    );

    // Second instance: one-cycle filter, reset high, tiny counters.
    mmt_sync_deglitch #(
        .FilterCycles (1),
        .CntWidth     (2),
        .ResetValue   (1'b1)
    ) u_dut1 (
        .clk        (clk),
        .rstn       (rstn),
        .in         (in_s),
        .out_level  (out1),
        .rise_pulse (rise1),
        .fall_pulse (fall1),
        .cnt_clr    (cnt_clr),
        .rise_cnt   (rcnt1),
        .fall_cnt   (fcnt1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_main(input string tag, input logic o, input logic r, input logic f);
        check_eq({tag, "_out"},  out0,  o);
        check_eq({tag, "_rise"}, rise0, r);
        check_eq({tag, "_fall"}, fall0, f);
    endtask

    function automatic logic [7:0] cexp(input int v);
        return STAT ? v[7:0] : 8'd0;
    endfunction

    // Reference for the one-cycle instance: a plain register of the input.
    logic       m1_out, m1_rise, m1_fall;
    logic [1:0] m1_rc, m1_fc;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m1_out  <= 1'b1;
            m1_rise <= 1'b0;
            m1_fall <= 1'b0;
            m1_rc   <= 2'd0;
            m1_fc   <= 2'd0;
        end else begin
            m1_out  <= in_s;
            m1_rise <= in_s & ~m1_out;
            m1_fall <= ~in_s & m1_out;
            if (!STAT || cnt_clr) begin
                m1_rc <= 2'd0;
                m1_fc <= 2'd0;
            end else begin
                if (m1_rise && m1_rc != 2'd3) m1_rc <= m1_rc + 2'd1;
                if (m1_fall && m1_fc != 2'd3) m1_fc <= m1_fc + 2'd1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk1_en) begin
            check_eq("fc1_out",  out1,  m1_out);
            check_eq("fc1_rise", rise1, m1_rise);
            check_eq("fc1_fall", fall1, m1_fall);
            check_eq("fc1_rcnt", rcnt1, m1_rc);
            check_eq("fc1_fcnt", fcnt1, m1_fc);
        end
    end

    initial begin
        rstn    = 1'b0;
        in_s    = 1'b0;
        cnt_clr = 1'b0;

        repeat (2) tick();
        check_main("rst", 1'b0, 1'b0, 1'b0);
        check_eq("rst_rcnt", rcnt0, 8'd0);
        check_eq("rst_fcnt", fcnt0, 8'd0);
        check_eq("rst_fc1_out", out1, 1'b1);

        // Release mid-cycle with in=1 held from the next edge.
        @(posedge clk);
        #3;
        rstn    = 1'b1;
        in_s    = 1'b1;
        chk1_en = 1'b1;
        repeat (3) begin
            tick();
            check_main("rise_wait", 1'b0, 1'b0, 1'b0);
        end
        tick();
        check_main("rise_acc", 1'b1, 1'b1, 1'b0);
        check_eq("rise_acc_rcnt", rcnt0, 8'd0);
        tick();
        check_main("rise_after", 1'b1, 1'b0, 1'b0);
        check_eq("rise_after_rcnt", rcnt0, cexp(1));

        in_s = 1'b0;
        repeat (3) begin
            tick();
            check_main("fall_wait", 1'b1, 1'b0, 1'b0);
        end
        tick();
        check_main("fall_acc", 1'b0, 1'b0, 1'b1);
        tick();
        check_main("fall_after", 1'b0, 1'b0, 1'b0);
        check_eq("fall_after_fcnt", fcnt0, cexp(1));

        // Three-cycle high glitch is rejected.
        in_s = 1'b1;
        repeat (3) begin
            tick();
            check_main("glitch_hi", 1'b0, 1'b0, 1'b0);
        end
        in_s = 1'b0;
        repeat (2) begin
            tick();
            check_main("glitch_hi_end", 1'b0, 1'b0, 1'b0);
        end
        check_eq("glitch_hi_rcnt", rcnt0, cexp(1));
        in_s = 1'b1;
        repeat (3) tick();
        check_main("rise2_wait", 1'b0, 1'b0, 1'b0);
        tick();
        check_main("rise2_acc", 1'b1, 1'b1, 1'b0);
        tick();
        check_eq("rise2_rcnt", rcnt0, cexp(2));

        // 0-0-1 then restart: the 1 sends the filter back to stable high.
        in_s = 1'b0;
        repeat (2) tick();
        in_s = 1'b1;
        tick();
        check_main("restart_mid", 1'b1, 1'b0, 1'b0);
        in_s = 1'b0;
        repeat (3) begin
            tick();
            check_main("restart_wait", 1'b1, 1'b0, 1'b0);
        end
        tick();
        check_main("restart_acc", 1'b0, 1'b0, 1'b1);
        tick();
        check_eq("restart_fcnt", fcnt0, cexp(2));

        // 300 further pairs drive both counters into saturation.
        for (int i = 0; i < 300; i++) begin
            if (i == 100) check_eq("sat_mid_rcnt", rcnt0, cexp(102));
            in_s = 1'b1;
            repeat (4) tick();
            in_s = 1'b0;
            repeat (4) tick();
        end
        tick();
        check_eq("sat_rcnt", rcnt0, cexp(255));
        check_eq("sat_fcnt", fcnt0, cexp(255));

        // Clear coincident with a rise pulse.
        in_s = 1'b1;
        repeat (4) tick();
        check_main("clr_rise", 1'b1, 1'b1, 1'b0);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        check_eq("clr_rcnt", rcnt0, 8'd0);
        check_eq("clr_fcnt", fcnt0, 8'd0);
        in_s = 1'b0;
        repeat (5) tick();
        check_eq("post_clr_fcnt", fcnt0, cexp(1));
        check_eq("post_clr_rcnt", rcnt0, 8'd0);

        // Asynchronous reset during high qualification at count 3.
        in_s = 1'b1;
        repeat (3) tick();
        check_main("qual3", 1'b0, 1'b0, 1'b0);
        #2;
        rstn = 1'b0;
        #1;
        check_main("async_rst", 1'b0, 1'b0, 1'b0);
        check_eq("async_rst_fcnt", fcnt0, 8'd0);
        check_eq("async_rst_rcnt", rcnt0, 8'd0);
        @(posedge clk);
        #3;
        rstn = 1'b1;
        repeat (3) begin
            tick();
            check_main("post_rst_wait", 1'b0, 1'b0, 1'b0);
        end
        tick();
        check_main("post_rst_acc", 1'b1, 1'b1, 1'b0);

        // Reset while high forces the output low at once and emits no pulse.
        tick();
        #2;
        rstn = 1'b0;
        #1;
        check_main("rst_hi", 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #3;
        in_s = 1'b0;
        rstn = 1'b1;
        repeat (2) begin
            tick();
            check_main("rst_hi_after", 1'b0, 1'b0, 1'b0);
        end

        chk1_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
